muldiv_exec: RTL and testbench



---
 rtl/muldiv_exec_if.sv | 26 ++
 rtl/muldiv_exec.sv | 137 +++++++++++++
 tb/tb_muldiv_exec.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_exec_if.sv
// Execute-stage link for the iterative multiply/divide unit.
// The pipeline side drives the operands; the unit returns stall, done pulse and the registered result.
interface muldiv_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  startE;
  logic [2:0]            funct3E;
  logic [DATA_WIDTH-1:0] rd1E;
  logic [DATA_WIDTH-1:0] rd2E;
  logic [4:0]            RdE;
  logic                  FlushE;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [4:0]            RdOut;

  modport master (
    output startE, funct3E, rd1E, rd2E, RdE, FlushE,
    input  busy, done, result, RdOut
  );

  modport slave (
    input  startE, funct3E, rd1E, rd2E, RdE, FlushE,
    output busy, done, result, RdOut
  );
endinterface

// File: rtl/muldiv_exec.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider on one
// shared accumulator pair, one bit per cycle, sequenced by IDLE/RUN/FIX/DONE.
module muldiv_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_exec_if.slave  io
);
  localparam int                    CW      = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]         LAST    = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                  state, state_next;
  logic [2:0]              op;
  logic [4:0]              rd_tag;
  logic [DATA_WIDTH-1:0]   acc_hi, acc_lo, divisor;
  logic                    neg_main, neg_rem;
  logic [CW-1:0]           count;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [4:0]              rd_out_q;

  // Incoming-op decode
  logic                    a_signed, b_signed, a_neg, b_neg, special, accept;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag, special_val;

  // Datapath step / fix-up
  logic [DATA_WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_WIDTH-1:0] prod, prod_s;
  logic [DATA_WIDTH-1:0]   quot_s, rem_s, fix_val;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    a_signed    = (io.funct3E == 3'b001) || (io.funct3E == 3'b010) ||
                  (io.funct3E == 3'b100) || (io.funct3E == 3'b110);
    b_signed    = (io.funct3E == 3'b001) || (io.funct3E == 3'b100) || (io.funct3E == 3'b110);
    a_neg       = a_signed && io.rd1E[DATA_WIDTH-1];
    b_neg       = b_signed && io.rd2E[DATA_WIDTH-1];
    // Negating 0x8000_0000 yields itself, which read as unsigned is the wanted 2^31.
    a_mag       = a_neg ? -io.rd1E : io.rd1E;
    b_mag       = b_neg ? -io.rd2E : io.rd2E;
    special     = 1'b0;
    special_val = '0;
    if (io.funct3E[2] && io.rd2E == '0) begin
      special     = 1'b1;
      special_val = io.funct3E[1] ? io.rd1E : '1;
    end else if (io.funct3E[2] && !io.funct3E[0] && io.rd1E == MIN_NEG && io.rd2E == '1) begin
      special     = 1'b1;
      special_val = io.funct3E[1] ? '0 : MIN_NEG;
    end
    accept = io.startE && !io.FlushE && (state == IDLE || state == DONE);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : '0);
    div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, divisor};
    prod      = {acc_hi, acc_lo};
    prod_s    = neg_main ? -prod : prod;
    quot_s    = neg_main ? -acc_lo : acc_lo;
    rem_s     = neg_rem ? -acc_hi : acc_hi;
    case (op)
      3'b000:                 fix_val = prod_s[DATA_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      3'b100, 3'b101:         fix_val = quot_s;
      default:                fix_val = rem_s;
    endcase
  end

  always_comb begin
    state_next = state;
    if (io.FlushE) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: state_next = io.startE ? (special ? DONE : RUN) : IDLE;
        RUN:        if (count == LAST) state_next = FIX;
        FIX:        state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  // Stall covers the start cycle itself; special cases finish at once and never stall.
  assign io.busy   = !io.FlushE && (state == RUN || state == FIX || (accept && !special));
  assign io.done   = (state == DONE);
  assign io.result = result_q;
  assign io.RdOut  = rd_out_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      rd_tag   <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      divisor  <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      count    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (accept) begin
      op       <= io.funct3E;
      rd_tag   <= io.RdE;
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= a_mag;
      divisor  <= b_mag;
      if (special) begin
        result_q <= special_val;
        rd_out_q <= io.RdE;
      end
    end else if (!io.FlushE && state == RUN) begin
      count <= count + CW'(1);
      if (op[2]) begin
        acc_hi <= div_diff[DATA_WIDTH] ? div_shift[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0];
        acc_lo <= {acc_lo[DATA_WIDTH-2:0], ~div_diff[DATA_WIDTH]};
      end else begin
        acc_hi <= mul_sum[DATA_WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
      end
    end else if (!io.FlushE && state == FIX) begin
      result_q <= fix_val;
      rd_out_q <= rd_tag;
    end
  end
endmodule

// File: tb/tb_muldiv_exec.sv
// Self-checking bench for muldiv_exec: a 64-bit arithmetic reference plus a cycle-level
// latency model, compared against the DUT every cycle, with directed and random ops.
module tb_muldiv_exec;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_exec_if #(.DATA_WIDTH(W)) bus ();
  muldiv_exec #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .io(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result straight from the RV32M definitions, using 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Cycle model: an accepted normal op reports 34 cycles after its start cycle, a special one
  // in the next cycle; results hold between done pulses; flush drops, reset clears.
  bit          m_inflight = 1'b0;
  bit          m_done     = 1'b0;
  int          m_cnt      = 0;
  logic [31:0] m_res      = '0;
  logic [31:0] m_pend     = '0;
  logic [4:0]  m_rd       = '0;
  logic [4:0]  m_pend_rd  = '0;

  always @(negedge clk) begin
    bit exp_busy;
    exp_busy = !bus.FlushE &&
               (m_inflight || (bus.startE && !is_special(bus.funct3E, bus.rd1E, bus.rd2E)));
    if (chk_en) begin
      check("busy",   {31'd0, bus.busy}, {31'd0, exp_busy});
      check("done",   {31'd0, bus.done}, {31'd0, m_done});
      check("result", bus.result, m_res);
      check("rdout",  {27'd0, bus.RdOut}, {27'd0, m_rd});
    end
    if (rst) begin
      m_inflight = 1'b0; m_done = 1'b0; m_res = '0; m_rd = '0;
    end else if (bus.FlushE) begin
      m_inflight = 1'b0; m_done = 1'b0;
    end else if (m_inflight) begin
      m_cnt--;
      m_done = (m_cnt == 0);
      if (m_done) begin
        m_inflight = 1'b0; m_res = m_pend; m_rd = m_pend_rd;
      end
    end else if (bus.startE) begin
      if (is_special(bus.funct3E, bus.rd1E, bus.rd2E)) begin
        m_done = 1'b1;
        m_res  = ref_result(bus.funct3E, bus.rd1E, bus.rd2E);
        m_rd   = bus.RdE;
      end else begin
        m_done     = 1'b0;
        m_inflight = 1'b1;
        m_cnt      = 34 - 1;
        m_pend     = ref_result(bus.funct3E, bus.rd1E, bus.rd2E);
        m_pend_rd  = bus.RdE;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.funct3E = f3; bus.rd1E = a; bus.rd2E = b; bus.RdE = rd;
  endtask

  // Called just after the accepting edge; returns cycles from that edge to the done cycle.
  task automatic wait_done(input bit junk, output int k);
    bit found = 1'b0;
    k = 0;
    while (!found && k < 100) begin
      @(negedge clk);
      k++;
      if (bus.done) found = 1'b1;
      else begin
        @(posedge clk); #1;
        if (junk && k < 20) begin
          bus.startE = 1'($urandom_range(0, 1));
          drive(3'($urandom), $urandom, $urandom, 5'($urandom));
        end else bus.startE = 1'b0;
      end
    end
    if (!found) check("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit junk, output int k);
    @(posedge clk); #1;
    drive(f3, a, b, rd);
    bus.startE = 1'b1;
    @(posedge clk); #1;
    bus.startE = 1'b0;
    wait_done(junk, k);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    bit          sp;
  } vec_t;

  vec_t vecs[12] = '{
    '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
    '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0},
    '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0},
    '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1},
    '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k, seen;
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          sp;

    rst = 1'b1; bus.startE = 1'b0; bus.FlushE = 1'b0;
    drive(3'd0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    #2;
    check("rst_busy",   {31'd0, bus.busy}, 32'd0);
    check("rst_done",   {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rdout",  {27'd0, bus.RdOut}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      check($sformatf("model%0d", i), ref_result(vecs[i].f3, vecs[i].a, vecs[i].b), vecs[i].exp);
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b0, k);
      check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
      check($sformatf("vec%0d_rdout", i), {27'd0, bus.RdOut}, i + 1);
      check($sformatf("vec%0d_latency", i), k, vecs[i].sp ? 1 : 34);
    end

    // Flush mid-run: no done, previous result (DIVU 100/7 = 14) survives.
    do_op(3'd5, 32'd100, 32'd7, 5'd20, 1'b0, k);
    @(posedge clk); #1;
    drive(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd21);
    bus.startE = 1'b1;
    @(posedge clk); #1;
    bus.startE = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.FlushE = 1'b1;
    #2 check("flush_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1 bus.FlushE = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("flush_no_done", seen, 0);
    check("flush_result_kept", bus.result, 32'd14);
    check("flush_busy_after", {31'd0, bus.busy}, 32'd0);

    // Reset twenty cycles into an op clears everything.
    @(posedge clk); #1;
    drive(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd22);
    bus.startE = 1'b1;
    @(posedge clk); #1;
    bus.startE = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #2;
    check("midrst_result", bus.result, 32'd0);
    check("midrst_rdout",  {27'd0, bus.RdOut}, 32'd0);
    check("midrst_busy",   {31'd0, bus.busy}, 32'd0);
    check("midrst_done",   {31'd0, bus.done}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("midrst_no_done", seen, 0);

    // Back-to-back: second op starts in the first op's done cycle; RUN-time start pulses ignored.
    @(posedge clk); #1;
    drive(3'd5, 32'd100, 32'd7, 5'd3);
    bus.startE = 1'b1;
    @(posedge clk); #1;
    bus.startE = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    #2;
    check("b2b_done1",   {31'd0, bus.done}, 32'd1);
    check("b2b_result1", bus.result, 32'd14);
    drive(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    bus.startE = 1'b1;
    @(posedge clk); #1;
    bus.startE = 1'b0;
    wait_done(1'b1, k);
    check("b2b_spacing", k, 34);
    check("b2b_result2", bus.result, 32'hFFFF_FFEB);
    check("b2b_rdout2",  {27'd0, bus.RdOut}, 32'd9);

    // Random ops, outputs checked every cycle against the model.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      f3 = 3'($urandom);
      a  = pick_operand();
      b  = ($urandom_range(0, 9) == 0) ? 32'd0 : pick_operand();
      sp = is_special(f3, a, b);
      do_op(f3, a, b, 5'($urandom), !sp && ($urandom_range(0, 1) == 1), k);
      check($sformatf("rand%0d_latency", i), k, sp ? 1 : 34);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
